// File: rtl/video_pkg.sv
// Shared constants, fetch-state encoding and row arithmetic for the video fetch path.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package video_pkg;

   localparam int WORDS_PER_LINE = 32;   // 16-bit words per displayed line
   localparam int ACTIVE_X       = 512;  // loads at x below this are visible pixels
   localparam int LINE_START_X   = 640;  // x at which the next line's context is set up
   localparam int Y_LAST         = 625;  // last y count of the frame
   localparam int SCROLL_NEUTRAL = 216;  // octal 0330: scroll value giving zero offset
   localparam int REDUCED_BASE   = 192;  // row offset of the 64-line reduced screen

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_t;

   // Memory row for a displayed line; all arithmetic wraps modulo 256 rows.
   function automatic logic [7:0] calc_row(input logic [7:0] line,
                                           input logic [7:0] scroll,
                                           input logic       full_screen);
      logic [7:0] r;
      r = line + scroll - 8'(SCROLL_NEUTRAL);
      if (!full_screen) r = r + 8'(REDUCED_BASE);
      return r;
   endfunction

endpackage

// File: rtl/video_fetch_if.sv
// Video RAM read port between the fetch unit (master) and the shared-RAM arbiter (slave).
// Latency: request held until a one-cycle ack; data valid in the ack cycle.
// Backpressure: the arbiter stalls simply by delaying vid_ack.
interface video_fetch_if;

   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vid_ack;
   logic [15:0] vid_data;

   modport master (output vid_req, output vid_addr, input vid_ack, input vid_data);
   modport slave  (input vid_req, input vid_addr, output vid_ack, output vid_data);

endinterface

// File: rtl/video_fifo2.sv
// Two-entry 16-bit prefetch FIFO with head-of-queue visible combinationally.
// Latency: a pushed word is at the head the cycle after the push edge.
// Backpressure: push while full without pop is dropped; pop while empty is a no-op; flush beats push.
module video_fifo2 (
   input  logic        clk25,
   input  logic        res,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [15:0] din,
   output logic        empty,
   output logic        full,
   output logic [15:0] head
);

   logic [15:0] e0, e1;
   logic [1:0]  cnt;
   logic        do_pop, do_push;

   assign empty   = (cnt == 2'd0);
   assign full    = (cnt == 2'd2);
   assign head    = e0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Entry shift register: e0 is always the oldest word.
   always_ff @(posedge clk25) begin
      if (!res) begin
         cnt <= 2'd0;
         e0  <= 16'd0;
         e1  <= 16'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) e0 <= din;
               else             e1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/video_fetch.sv
// Fetches one 16-bit screen word per 16-pixel slot from video RAM, applying scroll and reduced-screen offsets.
// Latency: request issues the cycle after the FSM sees room; words prefetched two ahead of the shifter.
// Backpressure: one outstanding request held until ack; fetch stalls while the FIFO is full; empty pop flags underrun.
module video_fetch
   import video_pkg::*;
(
   input  logic          clk25,
   input  logic          res,
   input  logic [9:0]    x,
   input  logic [9:0]    y,
   input  logic          load,
   input  logic [7:0]    scroll,
   input  logic          full_screen,
   video_fetch_if.master ram,
   output logic [15:0]   data,
   output logic          underrun
);

   fetch_state_t state, state_d;
   logic         issue;
   logic [7:0]   row;
   logic [5:0]   col;
   logic         line_active;
   logic         discard;
   logic [12:0]  addr;

   logic         line_setup;
   logic [9:0]   ny;
   logic [7:0]   ny_line;
   logic         pop_req;
   logic         take;
   logic         fifo_empty, fifo_full;
   logic [15:0]  fifo_head;

   assign line_setup = (x == 10'(LINE_START_X));
   assign ny         = (y == 10'(Y_LAST)) ? 10'd0 : y + 10'd1;
   assign ny_line    = ny[8:1];   // each memory row is shown on two scan lines
   assign pop_req    = load && (x < 10'(ACTIVE_X)) && line_active;
   assign take       = (state == ST_REQ) && ram.vid_ack && !discard;

   assign ram.vid_req  = (state == ST_REQ);
   assign ram.vid_addr = addr;
   assign data         = fifo_empty ? 16'd0 : fifo_head;

   video_fifo2 u_fifo (
      .clk25 (clk25),
      .res   (res),
      .push  (take),
      .pop   (pop_req),
      .flush (line_setup),
      .din   (ram.vid_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .head  (fifo_head)
   );

   // Fetch state register.
   always_ff @(posedge clk25) begin
      if (!res) state <= ST_IDLE;
      else      state <= state_d;
   end

   // Next-state: issue when there is room and work; never on the setup cycle, whose row/col are stale.
   always_comb begin
      state_d = state;
      issue   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!line_setup && line_active && !col[5] && !fifo_full && !discard) begin
               state_d = ST_REQ;
               issue   = 1'b1;
            end
         end
         ST_REQ: begin
            if (ram.vid_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line context, address capture and column/discard bookkeeping.
   always_ff @(posedge clk25) begin
      if (!res) begin
         row         <= 8'd0;
         col         <= 6'd0;
         line_active <= 1'b0;
         discard     <= 1'b0;
         addr        <= 13'd0;
      end else begin
         if (issue) addr <= {row, col[4:0]};
         if (line_setup) begin
            row         <= calc_row(ny_line, scroll, full_screen);
            line_active <= (ny < 10'd512) && (full_screen || (ny_line < 8'd64));
            col         <= 6'd0;
            // A request still in flight belongs to the old line; its data must be dropped.
            discard     <= (state == ST_REQ) && !ram.vid_ack;
         end else if ((state == ST_REQ) && ram.vid_ack) begin
            if (discard) discard <= 1'b0;
            else         col     <= col + 6'd1;
         end
      end
   end

   // Sticky underrun: the shifter wanted a word that had not arrived.
   always_ff @(posedge clk25) begin
      if (!res)                         underrun <= 1'b0;
      else if (pop_req && fifo_empty)   underrun <= 1'b1;
   end

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: models the sync generator and a latency-programmable RAM arbiter.
// Latency: arbiter ack latency set per scenario.
// Backpressure: arbiter can hold a request indefinitely or answer it with a marker word.
module tb_video_fetch;

   localparam int M_TOGGLE = 0;
   localparam int M_NORMAL = 1;
   localparam int M_HOLD   = 2;
   localparam int M_DEAD   = 3;

   logic        clk25 = 1'b0;
   logic        res;
   logic [9:0]  x, y;
   logic        load;
   logic [7:0]  scroll;
   logic        full_screen;
   logic [15:0] data;
   logic        underrun;
   logic        ack_r;
   logic [15:0] ack_dat;

   int          mode = M_TOGGLE;
   int          lat  = 2;
   int          n_vec = 0;
   int          n_err = 0;
   logic [12:0] addr_log[$];

   int          wait_cnt;
   int          dead_cnt;
   bit          armed;
   bit          dead_fired;

   always #5 clk25 = ~clk25;

   video_fetch_if ram_if ();
   assign ram_if.vid_ack  = ack_r;
   assign ram_if.vid_data = ack_dat;

   video_fetch dut (
      .clk25       (clk25),
      .res         (res),
      .x           (x),
      .y           (y),
      .load        (load),
      .scroll      (scroll),
      .full_screen (full_screen),
      .ram         (ram_if),
      .data        (data),
      .underrun    (underrun)
   );

   // Arbiter model: answers each request after lat edges with a word tagged by its address.
   task automatic normal_step();
      if (ack_r) begin
         ack_r    = 1'b0;
         wait_cnt = 0;
      end else if (ram_if.vid_req) begin
         wait_cnt++;
         if (wait_cnt >= lat) begin
            ack_r   = 1'b1;
            ack_dat = 16'h8000 | {3'b000, ram_if.vid_addr};
            addr_log.push_back(ram_if.vid_addr);
         end
      end
   endtask

   initial begin
      ack_r = 1'b0; ack_dat = 16'h0000;
      wait_cnt = 0; dead_cnt = 0; armed = 0; dead_fired = 0;
      forever begin
         @(posedge clk25); #2;
         if (mode != M_DEAD) begin
            dead_fired = 0;
            armed      = 0;
         end
         case (mode)
            M_TOGGLE: begin
               ack_r   = ~ack_r;
               ack_dat = 16'h5A5A;
            end
            M_HOLD: begin
               ack_r    = 1'b0;
               wait_cnt = 0;
            end
            M_DEAD: begin
               if (dead_fired) begin
                  normal_step();
               end else begin
                  if (x == 10'd640) begin
                     armed    = 1;
                     dead_cnt = 0;
                  end else if (armed) begin
                     dead_cnt++;
                  end
                  if (armed && dead_cnt == 3) begin
                     ack_r      = 1'b1;
                     ack_dat    = 16'hDEAD;
                     dead_fired = 1;
                     armed      = 0;
                     wait_cnt   = 0;
                  end
               end
            end
            default: normal_step();
         endcase
      end
   end

   // Sync generator: 800 clocks per line, y wraps after 625.
   task automatic tick();
      @(posedge clk25); #1;
      if (x == 10'd799) begin
         x = 10'd0;
         y = (y == 10'd625) ? 10'd0 : y + 10'd1;
      end else begin
         x = x + 10'd1;
      end
      load = (x[3:0] == 4'd0);
   endtask

   task automatic goto_x(input logic [9:0] tx, input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < 2000; i++) begin
         if (x == tx) begin
            hit = 1;
            break;
         end
         tick();
      end
      n_vec++;
      if (!hit) begin
         n_err++;
         $display("FAIL %s goto: x=%0d never reached %0d", tag, x, tx);
      end
   endtask

   // Runs through the next line setup and its visible part, checking every shifter word and the request order.
   task automatic run_display(input logic [7:0] exp_row, input bit exp_active, input string tag);
      int          base, k, cnt, exp_cnt;
      bit          wrapped, done;
      logic [15:0] exp_d;
      logic [12:0] exp_a;
      base = addr_log.size(); k = 0; wrapped = 0; done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         tick();
         if (x == 10'd0) wrapped = 1;
         if (wrapped && x < 10'd512 && load) begin
            exp_d = exp_active ? (16'h8000 | {3'b000, exp_row, k[4:0]}) : 16'h0000;
            n_vec++;
            if (data !== exp_d) begin
               n_err++;
               $display("FAIL %s data word %0d: got %h want %h", tag, k, data, exp_d);
            end
            k++;
         end
         if (wrapped && x == 10'd520) done = 1;
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL %s line timeout: got x=%0d want 520", tag, x);
      end
      cnt     = addr_log.size() - base;
      exp_cnt = exp_active ? 32 : 0;
      n_vec++;
      if (cnt != exp_cnt) begin
         n_err++;
         $display("FAIL %s request count: got %0d want %0d", tag, cnt, exp_cnt);
      end
      for (int i = 0; i < cnt && i < 32; i++) begin
         exp_a = {exp_row, i[4:0]};
         n_vec++;
         if (addr_log[base + i] !== exp_a) begin
            n_err++;
            $display("FAIL %s address %0d: got %0d want %0d", tag, i, addr_log[base + i], exp_a);
         end
      end
   endtask

   task automatic test_reset();
      res = 1'b0; x = 10'd100; y = 10'd100; load = 1'b0;
      scroll = 8'd216; full_screen = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk25); #1;
         n_vec++; if (ram_if.vid_req !== 1'b0)    begin n_err++; $display("FAIL reset vid_req: got %b want 0", ram_if.vid_req); end
         n_vec++; if (ram_if.vid_addr !== 13'd0)  begin n_err++; $display("FAIL reset vid_addr: got %0d want 0", ram_if.vid_addr); end
         n_vec++; if (data !== 16'h0000)          begin n_err++; $display("FAIL reset data: got %h want 0000", data); end
         n_vec++; if (underrun !== 1'b0)          begin n_err++; $display("FAIL reset underrun: got %b want 0", underrun); end
      end
      res  = 1'b1;
      mode = M_NORMAL;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_vec++; if (data !== 16'h0000)       begin n_err++; $display("FAIL post_reset data: got %h want 0000", data); end
         n_vec++; if (ram_if.vid_req !== 1'b0) begin n_err++; $display("FAIL post_reset vid_req: got %b want 0", ram_if.vid_req); end
      end
   endtask

   task automatic test_neutral();
      lat = 2; scroll = 8'd216; full_screen = 1'b1;
      x = 10'd636; y = 10'd625;
      run_display(8'd0, 1'b1, "neutral");
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL neutral underrun: got %b want 0", underrun); end
   endtask

   task automatic test_scroll();
      scroll = 8'd217; x = 10'd636; y = 10'd625;
      run_display(8'd1, 1'b1, "scroll217");
      scroll = 8'd215; x = 10'd636; y = 10'd625;
      run_display(8'd255, 1'b1, "scroll215_wrap");
   endtask

   task automatic test_reduced();
      full_screen = 1'b0; scroll = 8'd216;
      x = 10'd636; y = 10'd199;
      run_display(8'd0, 1'b0, "reduced_line100");
      x = 10'd636; y = 10'd625;
      run_display(8'd192, 1'b1, "reduced_line0");
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reduced underrun: got %b want 0", underrun); end
      full_screen = 1'b1;
   endtask

   task automatic test_underrun();
      bit wrapped, done;
      lat = 20; scroll = 8'd216; full_screen = 1'b1;
      x = 10'd636; y = 10'd625;
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_start: got %b want 0", underrun); end
      wrapped = 0; done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         tick();
         if (x == 10'd0) wrapped = 1;
         if (wrapped) begin
            case (x)
               10'd48: begin
                  n_vec++; if (data !== 16'h8003) begin n_err++; $display("FAIL slow word3: got %h want 8003", data); end
               end
               10'd64: begin
                  n_vec++; if (data !== 16'h8004) begin n_err++; $display("FAIL slow word4: got %h want 8004", data); end
                  n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL slow underrun@64: got %b want 0", underrun); end
               end
               10'd80: begin
                  n_vec++; if (data !== 16'h0000) begin n_err++; $display("FAIL slow empty@80: got %h want 0000", data); end
                  n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL slow underrun@80: got %b want 0", underrun); end
               end
               10'd81: begin
                  n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL slow underrun@81: got %b want 1", underrun); end
               end
               10'd520: done = 1;
               default: ;
            endcase
         end
      end
      n_vec++; if (!done) begin n_err++; $display("FAIL slow line timeout: got x=%0d want 520", x); end
      lat = 2;
      goto_x(10'd639, "drain");
      run_display(8'd0, 1'b1, "after_underrun");
      n_vec++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun sticky: got %b want 1", underrun); end
   endtask

   task automatic test_discard();
      mode = M_HOLD;
      x = 10'd636; y = 10'd10;
      goto_x(10'd641, "hold_setup");
      tick();
      goto_x(10'd639, "hold_line");
      n_vec++; if (ram_if.vid_req !== 1'b1)    begin n_err++; $display("FAIL hold vid_req: got %b want 1", ram_if.vid_req); end
      n_vec++; if (ram_if.vid_addr !== 13'd160) begin n_err++; $display("FAIL hold vid_addr: got %0d want 160", ram_if.vid_addr); end
      mode = M_DEAD;
      run_display(8'd6, 1'b1, "discard");
      n_vec++; if (dead_fired !== 1'b1) begin n_err++; $display("FAIL discard ack: got %b want 1", dead_fired); end
      mode = M_NORMAL;
   endtask

   initial begin
      test_reset();
      test_neutral();
      test_scroll();
      test_reduced();
      test_underrun();
      test_discard();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/video_fetch.md
Name: video_fetch

Overview:
- Fetches screen words from video RAM and presents them to the pixel shifter one 16-bit word per 16-pixel slot.
- Sits between the shared-RAM arbiter and the shifter, driven by the sync generator's x/y counters.
- Applies the BK scroll offset and the reduced-screen mode.
- Prefetches through a 2-entry FIFO so that arbiter latency is hidden.

Parameters:
- LINE_START_X, 640, x value at which the next line's fetch context is set up.
- Y_LAST, 625, last y count of the frame; the next y after Y_LAST is 0.
- SCROLL_NEUTRAL, 216, scroll value (octal 0330) that gives zero offset.
- REDUCED_BASE, 192, row offset used in reduced-screen mode.

Ports:
- clk25  in  1  pixel clock; all logic on posedge.
- res  in  1  synchronous reset, active-low (0 = reset).
- x  in  10  horizontal counter from sync generator.
- y  in  10  vertical counter from sync generator.
- load  in  1  shifter load strobe, high when x[3:0]==0.
- scroll  in  8  scroll register value.
- full_screen  in  1  1 = 256-line screen; 0 = reduced 64-line screen.
- vid_req  out  1  RAM read request.
- vid_addr  out  13  RAM word address (row*32 + col).
- vid_ack  in  1  one-cycle pulse; vid_data is valid in the same cycle.
- vid_data  in  16  RAM read data.
- data  out  16  word presented to the shifter.
- underrun  out  1  sticky flag: a word was needed while the FIFO was empty.

Behaviour:
- Reset (res==0 at posedge):
  - vid_req=0, vid_addr=0, data=0, underrun=0.
  - FIFO empty, col=0, line_active=0, discard=0, state IDLE.
- Line setup at x==LINE_START_X:
  - ny = (y==Y_LAST) ? 0 : y+1; line = ny[8:1] (each memory row is shown twice).
  - line_active = (ny<512) && (full_screen || line<64).
  - Full mode: row = (line + scroll - SCROLL_NEUTRAL) mod 256.
  - Reduced mode: row = (line + scroll - SCROLL_NEUTRAL + REDUCED_BASE) mod 256.
  - scroll and full_screen are sampled only here; changes mid-line take effect on the next line.
  - FIFO is flushed and col is set to 0.
  - If a request is outstanding, discard=1.
- Fetch FSM:
  - IDLE -> REQ when line_active && col<32 && FIFO not full && !discard. On entry vid_addr = row*32+col and vid_req=1.
  - REQ: vid_req and vid_addr stay stable until vid_ack.
  - On vid_ack with discard=0: push vid_data, col++, vid_req=0, go to IDLE.
  - On vid_ack with discard=1: drop the data, clear discard, vid_req=0, go to IDLE. The next request may issue the following cycle.
  - At most one request is outstanding; vid_req is never withdrawn before ack.
- Output:
  - data always equals the FIFO head, or 0 when the FIFO is empty.
  - Pop on posedge when load && x<512 && line_active.
  - The shifter samples data on that same edge, so the popped word is the one it latches.
  - Pop on an empty FIFO: no state change except underrun=1.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - If line_active=0, no pops and no requests occur, and data=0.
- underrun is cleared only by reset.
- Address arithmetic: row is 8-bit modulo and col is 5-bit, so vid_addr = {row, col}.

Decomposition:
- Shared package video_pkg: WORDS_PER_LINE=32, ACTIVE_X=512, LINE_START_X, Y_LAST, SCROLL_NEUTRAL, REDUCED_BASE, fetch-state encoding.
- Sub-module video_fifo2: 2-entry, 16-bit, with push, pop, flush, empty, full and head.
  - Same-cycle push+pop supported.
  - flush has priority over push.

Test Plan:
- Hold res=0 for 3 cycles with vid_ack toggling -> vid_req=0, data=0, underrun=0, no FIFO pushes.
- scroll=216, full_screen=1, ack latency 2, y=Y_LAST -> at x=640 the first request is vid_addr 0; line 0 issues addresses 0..31 in order; data on the 32 loads equals vid_data tagged 0..31; underrun=0.
- scroll=217, line 0 -> addresses 32..63. scroll=215, line 0 -> addresses 8160..8191 (row 255, wrap).
- full_screen=0, scroll=216, y giving line 100 -> no vid_req during that line, data=0. Line 0 -> addresses 6144..6175.
- Ack latency 20 cycles -> underrun=1 at the first load that finds the FIFO empty; underrun stays 1 across later lines.
- Request outstanding at x=LINE_START_X, ack 3 cycles later with 0xDEAD -> 0xDEAD is never presented on data; the next request uses the new row with col 0.
